// File: rtl/fifo_ring_ctrl_if.sv
// Request/data/status bundle between the button/switch front end and fifo_ring_ctrl.
// The master side drives requests and write data; the slave side (the FIFO) returns data and status.
interface fifo_ring_ctrl_if #(
    parameter int WL    = 8,
    parameter int DEPTH = 50,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          wReq;
    logic          rReq;
    logic          auto;
    logic          errClr;
    logic [WL-1:0] din;
    logic [WL-1:0] dout;
    logic          valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          overflow;
    logic          underflow;
    logic          error;

    modport master (
        output wReq, rReq, auto, errClr, din,
        input  dout, valid, count, empty, full, almost_empty, almost_full,
               overflow, underflow, error
    );

    modport slave (
        input  wReq, rReq, auto, errClr, din,
        output dout, valid, count, empty, full, almost_empty, almost_full,
               overflow, underflow, error
    );
endinterface

// File: rtl/fifo_ring_ctrl.sv
// Parametrised ring FIFO with arbitrary depth, occupancy flags, sticky errors,
// optional rising-edge request qualification and a rotate mode for display playback.
module fifo_ring_ctrl #(
    parameter int WL     = 8,
    parameter int DEPTH  = 50,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int EDGE   = 1
) (
    input  logic            CLK,
    input  logic            RST,
    fifo_ring_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WL-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [WL-1:0] r_dout;
    logic          r_valid;
    logic          r_ovf, r_unf;
    logic          r_wreq_q, r_rreq_q;

    logic          w_wr_stb, w_rd_stb;
    logic          w_empty, w_full;
    logic          w_rot, w_do_rd, w_do_wr;
    logic          w_ovf_evt, w_unf_evt;
    logic          w_mem_we;
    logic [WL-1:0] w_mem_wd, w_head;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_wr_stb = (EDGE != 0) ? (bus.wReq & ~r_wreq_q) : bus.wReq;
    assign w_rd_stb = (EDGE != 0) ? (bus.rReq & ~r_rreq_q) : bus.rReq;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_head   = r_mem[r_rptr];

    // A read frees a slot first, so a write against a full FIFO succeeds when paired with a read.
    always_comb begin
        w_rot     = bus.auto & ~w_empty;
        w_do_rd   = ~bus.auto & w_rd_stb & ~w_empty;
        w_do_wr   = ~bus.auto & w_wr_stb & (~w_full | w_do_rd);
        w_ovf_evt = ~bus.auto & w_wr_stb & w_full & ~w_do_rd;
        w_unf_evt = ~bus.auto & w_rd_stb & w_empty;
        w_mem_we  = w_do_wr | w_rot;
        w_mem_wd  = bus.auto ? w_head : bus.din;
    end

    // NOTE: storage has no reset; a location is only ever read after it has been written.
    always_ff @(posedge CLK) begin
        if (w_mem_we)
            r_mem[r_wptr] <= w_mem_wd;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_wreq_q <= 1'b0;
            r_rreq_q <= 1'b0;
        end else begin
            r_wreq_q <= bus.wReq;
            r_rreq_q <= bus.rReq;
            r_valid  <= w_do_rd | w_rot;
            if (w_do_rd | w_rot)
                r_dout <= w_head;
            if (w_do_wr | w_rot)
                r_wptr <= f_inc(r_wptr);
            if (w_do_rd | w_rot)
                r_rptr <= f_inc(r_rptr);
            if (w_do_wr & ~w_do_rd)
                r_count <= r_count + CW'(1);
            else if (w_do_rd & ~w_do_wr)
                r_count <= r_count - CW'(1);
            // A fresh error event outranks a clear in the same cycle.
            r_ovf <= w_ovf_evt | (r_ovf & ~bus.errClr);
            r_unf <= w_unf_evt | (r_unf & ~bus.errClr);
        end
    end

    assign bus.dout         = r_dout;
    assign bus.valid        = r_valid;
    assign bus.count        = r_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_empty = (r_count <= CW'(AE_LVL));
    assign bus.almost_full  = (r_count >= CW'(AF_LVL));
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;
    assign bus.error        = r_ovf | r_unf;
endmodule

// File: tb/tb_fifo_ring_ctrl.sv
// Directed bench: a 50-deep edge-qualified instance and a 5-deep level-mode instance
// share one clock and reset; expected values are hand-derived constants and a small queue.
module tb_fifo_ring_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fifo_ring_ctrl_if #(.WL(8), .DEPTH(50)) bus_a ();
    fifo_ring_ctrl_if #(.WL(8), .DEPTH(5))  bus_b ();

    fifo_ring_ctrl #(.WL(8), .DEPTH(50), .EDGE(1)) u_dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (bus_a)
    );

    fifo_ring_ctrl #(.WL(8), .DEPTH(5), .EDGE(0)) u_dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] d, input int hold);
        bus_a.din  = d;
        bus_a.wReq = 1'b1;
        repeat (hold) cyc();
        bus_a.wReq = 1'b0;
        cyc();
    endtask

    task automatic a_read(input int hold, output logic [7:0] d, output int pulses);
        pulses     = 0;
        bus_a.rReq = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cyc();
            if (bus_a.valid) pulses++;
        end
        bus_a.rReq = 1'b0;
        cyc();
        if (bus_a.valid) pulses++;
        d = bus_a.dout;
    endtask

    task automatic a_clear_errors();
        bus_a.errClr = 1'b1;
        cyc();
        bus_a.errClr = 1'b0;
    endtask

    logic [7:0] rd;
    int         pulses;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus_a.wReq = 0; bus_a.rReq = 0; bus_a.auto = 0; bus_a.errClr = 0; bus_a.din = '0;
        bus_b.wReq = 0; bus_b.rReq = 0; bus_b.auto = 0; bus_b.errClr = 0; bus_b.din = '0;
        repeat (2) cyc();

        check("rst_dout",   bus_a.dout, 0);
        check("rst_valid",  bus_a.valid, 0);
        check("rst_count",  bus_a.count, 0);
        check("rst_empty",  bus_a.empty, 1);
        check("rst_full",   bus_a.full, 0);
        check("rst_ae",     bus_a.almost_empty, 1);
        check("rst_af",     bus_a.almost_full, 0);
        check("rst_ovf",    bus_a.overflow, 0);
        check("rst_unf",    bus_a.underflow, 0);
        check("rst_err",    bus_a.error, 0);
        rst = 1'b0;
        cyc();

        // Held buttons: five cycles high each yields one operation.
        a_write(8'd10, 5);
        a_write(8'd20, 5);
        a_write(8'd30, 5);
        check("held_wr_count", bus_a.count, 3);
        a_read(5, rd, pulses);
        check("held_rd0_data", rd, 10);
        check("held_rd0_pulses", pulses, 1);
        a_read(5, rd, pulses);
        check("held_rd1_data", rd, 20);
        check("held_rd1_pulses", pulses, 1);
        a_read(5, rd, pulses);
        check("held_rd2_data", rd, 30);
        check("held_rd2_pulses", pulses, 1);
        check("held_empty", bus_a.empty, 1);

        // Fill to DEPTH with words 1..50.
        for (int i = 0; i < 50; i++) begin
            a_write(8'(i + 1), 1);
            if (i == 46) check("fill_af_at47", bus_a.almost_full, 0);
            if (i == 47) check("fill_af_at48", bus_a.almost_full, 1);
            if (i == 48) check("fill_full_at49", bus_a.full, 0);
        end
        check("fill_count", bus_a.count, 50);
        check("fill_full", bus_a.full, 1);
        a_write(8'hEE, 1);
        check("ovf_flag", bus_a.overflow, 1);
        check("ovf_error", bus_a.error, 1);
        check("ovf_count", bus_a.count, 50);

        // Clear colliding with a new overflow keeps the flag; a plain clear drops it.
        bus_a.din = 8'hEF; bus_a.wReq = 1'b1; bus_a.errClr = 1'b1;
        cyc();
        check("clr_vs_evt_ovf", bus_a.overflow, 1);
        bus_a.wReq = 1'b0;
        cyc();
        check("clr_ovf", bus_a.overflow, 0);
        check("clr_error", bus_a.error, 0);
        bus_a.errClr = 1'b0;

        // Full FIFO, simultaneous write 0xAA and read.
        bus_a.din = 8'hAA; bus_a.wReq = 1'b1; bus_a.rReq = 1'b1;
        cyc();
        check("fullrw_dout", bus_a.dout, 1);
        check("fullrw_valid", bus_a.valid, 1);
        check("fullrw_count", bus_a.count, 50);
        check("fullrw_ovf", bus_a.overflow, 0);
        bus_a.wReq = 1'b0; bus_a.rReq = 1'b0;
        cyc();
        for (int i = 0; i < 49; i++) begin
            a_read(1, rd, pulses);
            check("drain_data", rd, 32'(i + 2));
        end
        a_read(1, rd, pulses);
        check("drain_last", rd, 8'hAA);
        check("drain_empty", bus_a.empty, 1);

        // Read on empty: refused, dout kept.
        a_read(1, rd, pulses);
        check("unf_flag", bus_a.underflow, 1);
        check("unf_dout_kept", rd, 8'hAA);
        check("unf_no_valid", pulses, 0);
        a_clear_errors();
        check("unf_cleared", bus_a.underflow, 0);

        // Empty FIFO, simultaneous write 0x55 and read.
        bus_a.din = 8'h55; bus_a.wReq = 1'b1; bus_a.rReq = 1'b1;
        cyc();
        check("emptyrw_count", bus_a.count, 1);
        check("emptyrw_unf", bus_a.underflow, 1);
        check("emptyrw_valid", bus_a.valid, 0);
        check("emptyrw_dout", bus_a.dout, 8'hAA);
        bus_a.wReq = 1'b0; bus_a.rReq = 1'b0;
        cyc();
        a_read(1, rd, pulses);
        check("emptyrw_next", rd, 8'h55);
        a_clear_errors();

        // Rotate mode with button activity that must be ignored.
        a_write(8'd1, 1);
        a_write(8'd2, 1);
        a_write(8'd3, 1);
        bus_a.auto = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin bus_a.din = 8'h77; bus_a.wReq = 1'b1; end
            if (k == 4) bus_a.rReq = 1'b1;
            if (k == 5) bus_a.rReq = 1'b0;
            cyc();
            check("auto_dout", bus_a.dout, 32'(k % 3 + 1));
            check("auto_valid", bus_a.valid, 1);
            check("auto_count", bus_a.count, 3);
        end
        bus_a.auto = 1'b0;
        cyc();
        check("auto_off_count", bus_a.count, 3);
        check("auto_off_valid", bus_a.valid, 0);
        check("auto_off_error", bus_a.error, 0);
        bus_a.wReq = 1'b0;
        cyc();
        a_read(1, rd, pulses);
        check("auto_after_rd0", rd, 2);
        a_read(1, rd, pulses);
        check("auto_after_rd1", rd, 3);
        a_read(1, rd, pulses);
        check("auto_after_rd2", rd, 1);

        // DEPTH=5 level mode: a two-cycle request is two writes.
        bus_b.din = 8'hB0; bus_b.wReq = 1'b1;
        cyc();
        bus_b.din = 8'hB1;
        cyc();
        bus_b.wReq = 1'b0;
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        check("b_level_count", bus_b.count, 2);
        check("b_ae_at2", bus_b.almost_empty, 1);
        check("b_af_at2", bus_b.almost_full, 0);

        // Twelve write/read pairs walk both pointers across the 4 -> 0 wrap.
        for (int i = 0; i < 12; i++) begin
            bus_b.din = 8'(8'hC0 + i); bus_b.wReq = 1'b1; bus_b.rReq = 1'b1;
            cyc();
            exp_v = exp_q.pop_front();
            exp_q.push_back(8'(8'hC0 + i));
            check("b_wrap_dout", bus_b.dout, exp_v);
            check("b_wrap_valid", bus_b.valid, 1);
            check("b_wrap_count", bus_b.count, 2);
        end
        bus_b.rReq = 1'b0;
        bus_b.din  = 8'hD0;
        cyc();
        bus_b.wReq = 1'b0;
        check("b_count3", bus_b.count, 3);
        check("b_ae_at3", bus_b.almost_empty, 0);
        check("b_af_at3", bus_b.almost_full, 1);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_b_count", bus_b.count, 0);
        check("arst_b_empty", bus_b.empty, 1);
        check("arst_b_dout", bus_b.dout, 0);
        check("arst_b_af", bus_b.almost_full, 0);
        check("arst_a_dout", bus_a.dout, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        bus_b.din = 8'hE1; bus_b.wReq = 1'b1;
        cyc();
        bus_b.wReq = 1'b0; bus_b.rReq = 1'b1;
        cyc();
        bus_b.rReq = 1'b0;
        check("post_rst_dout", bus_b.dout, 8'hE1);
        check("post_rst_count", bus_b.count, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
